// File: rtl/exec_pkg.sv
// Shared types and constants for the execute stage: operation/branch encodings, FSM states,
// and divider special-case constants.
package exec_pkg;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } exec_op_t;

  typedef enum logic [3:0] {
    BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU, BR_JAL, BR_JALR
  } br_op_t;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t MUL  = 2'd1;
  localparam state_t DIV  = 2'd2;
  localparam state_t WB   = 2'd3;

  // Sliced to XLEN by users. Signed MIN / -1 falls out of the magnitude path as MIN rem 0.
  localparam logic [63:0] DIV0_QUOT = '1;
  localparam logic [63:0] OVF_REM   = '0;

  function automatic logic is_mul_op(exec_op_t op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

  function automatic logic is_div_op(exec_op_t op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/exec_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, the first computed in the start
// cycle, with sign fix-up and divide-by-zero override on the outputs.
module exec_div_iter
  import exec_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            signed_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] quot_o,
  output logic [XLEN-1:0] rem_o
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  logic            busy_q, neg_q_q, neg_r_q, div0_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q, a_q;

  logic            a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b, cur_rem, cur_quo, cur_dvs, rem_step;
  logic [XLEN:0]   shifted, diff;
  logic            q_bit;

  assign a_neg = signed_i & a_i[XLEN-1];
  assign b_neg = signed_i & b_i[XLEN-1];
  assign mag_a = a_neg ? -a_i : a_i;
  assign mag_b = b_neg ? -b_i : b_i;

  // The start cycle iterates on the fresh operands so XLEN bits finish in XLEN cycles.
  always_comb begin
    cur_rem = start_i ? '0 : rem_q;
    cur_quo = start_i ? mag_a : quo_q;
    cur_dvs = start_i ? mag_b : dvs_q;
    shifted = {cur_rem, cur_quo[XLEN-1]};
    diff    = shifted - {1'b0, cur_dvs};
    q_bit   = ~diff[XLEN];
    rem_step = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      a_q     <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      div0_q  <= 1'b0;
    end else if (start_i) begin
      busy_q  <= 1'b1;
      cnt_q   <= CW'(1);
      rem_q   <= rem_step;
      quo_q   <= {cur_quo[XLEN-2:0], q_bit};
      dvs_q   <= mag_b;
      a_q     <= a_i;
      neg_q_q <= a_neg ^ b_neg;
      neg_r_q <= a_neg;
      div0_q  <= (b_i == '0);
    end else if (busy_q) begin
      rem_q <= rem_step;
      quo_q <= {cur_quo[XLEN-2:0], q_bit};
      cnt_q <= cnt_q + CW'(1);
      if (cnt_q == LAST) busy_q <= 1'b0;
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == LAST);
  assign quot_o = div0_q ? DIV0_QUOT[XLEN-1:0] : (neg_q_q ? -quo_q : quo_q);
  assign rem_o  = div0_q ? a_q : (neg_r_q ? -rem_q : rem_q);

endmodule

// File: rtl/exec_stage_mc.sv
// Execute stage: single-cycle ALU/branch, multi-cycle MUL, iterative DIV, registered output slot.
// Optional operand forwarding from the memory stage is enabled by defining EXEC_FWD_EN.
`ifndef CONTROL_BIT
`define CONTROL_BIT 8
`endif

module exec_stage_mc
  import exec_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned CTRL_W     = `CONTROL_BIT,
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              decode_valid_i,
  output logic              decode_ready_o,
  input  exec_op_t          decode_op_i,
  input  br_op_t            decode_br_i,
  input  logic              decode_src2_imm_i,
  input  logic [CTRL_W-1:0] decode_control_i,
  input  logic [XLEN-1:0]   decode_rs1_i,
  input  logic [XLEN-1:0]   decode_rs2_i,
  input  logic [XLEN-1:0]   decode_imm_i,
  input  logic [4:0]        decode_rd_addr_i,
  input  logic [XLEN-1:0]   decode_pc_i,
`ifdef EXEC_FWD_EN
  input  logic [4:0]        decode_rs1_addr_i,
  input  logic [4:0]        decode_rs2_addr_i,
  input  logic              fwd_mem_valid_i,
  input  logic [4:0]        fwd_mem_rd_i,
  input  logic [XLEN-1:0]   fwd_mem_data_i,
`endif
  output logic              ftch_flush_o,
  output logic [XLEN-1:0]   ftch_target_addr_o,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic [CTRL_W-1:0] mem_control_o,
  output logic [XLEN-1:0]   mem_result_o,
  output logic [XLEN-1:0]   mem_data_o,
  output logic [4:0]        mem_rd_addr_o
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned CW  = $clog2(MUL_CYCLES + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);

  logic [XLEN-1:0] rs1_val, rs2_val, op_b, alu_res, jalr_sum, br_target, link_addr;
  logic            br_taken, accept, out_free, div_start, div_busy, div_done;
  logic [XLEN-1:0] div_quot, div_rem, mul_res, wb_res;
  logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, mul_prod;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  exec_op_t          op_q, op_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d, mem_ctrl_q, mem_ctrl_d;
  logic [4:0]        rd_q, rd_d, mem_rd_q, mem_rd_d;
  logic [XLEN-1:0]   data_q, data_d, mem_data_q, mem_data_d, mem_res_q, mem_res_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic              mem_valid_q, mem_valid_d;

`ifdef EXEC_FWD_EN
  assign rs1_val = (fwd_mem_valid_i && fwd_mem_rd_i != 5'd0 && fwd_mem_rd_i == decode_rs1_addr_i)
                   ? fwd_mem_data_i : decode_rs1_i;
  assign rs2_val = (fwd_mem_valid_i && fwd_mem_rd_i != 5'd0 && fwd_mem_rd_i == decode_rs2_addr_i)
                   ? fwd_mem_data_i : decode_rs2_i;
`else
  assign rs1_val = decode_rs1_i;
  assign rs2_val = decode_rs2_i;
`endif

  assign op_b = decode_src2_imm_i ? decode_imm_i : rs2_val;

  always_comb begin
    alu_res = '0;
    case (decode_op_i)
      OP_ADD:  alu_res = rs1_val + op_b;
      OP_SUB:  alu_res = rs1_val - op_b;
      OP_SLL:  alu_res = rs1_val << op_b[SHW-1:0];
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(rs1_val) < $signed(op_b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, rs1_val < op_b};
      OP_XOR:  alu_res = rs1_val ^ op_b;
      OP_SRL:  alu_res = rs1_val >> op_b[SHW-1:0];
      OP_SRA:  alu_res = $signed(rs1_val) >>> op_b[SHW-1:0];
      OP_OR:   alu_res = rs1_val | op_b;
      OP_AND:  alu_res = rs1_val & op_b;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (decode_br_i)
      BR_EQ:   br_taken = (rs1_val == rs2_val);
      BR_NE:   br_taken = (rs1_val != rs2_val);
      BR_LT:   br_taken = ($signed(rs1_val) < $signed(rs2_val));
      BR_GE:   br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      BR_LTU:  br_taken = (rs1_val < rs2_val);
      BR_GEU:  br_taken = (rs1_val >= rs2_val);
      BR_JAL, BR_JALR: br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
  end

  assign jalr_sum  = rs1_val + decode_imm_i;
  assign br_target = (decode_br_i == BR_JALR) ? {jalr_sum[XLEN-1:1], 1'b0}
                                              : decode_pc_i + decode_imm_i;
  assign link_addr = decode_pc_i + XLEN'(4);

  assign out_free       = !mem_valid_q || mem_ready_i;
  assign decode_ready_o = (state_q == IDLE) && out_free;
  assign accept         = decode_valid_i && decode_ready_o;
  assign ftch_flush_o   = accept && br_taken;
  assign ftch_target_addr_o = br_target;

  // MULHSU treats rs1 as signed, rs2 unsigned; the low half is sign-agnostic.
  assign mul_a_ext = {{XLEN{(decode_op_i inside {OP_MULH, OP_MULHSU}) & rs1_val[XLEN-1]}}, rs1_val};
  assign mul_b_ext = {{XLEN{(decode_op_i == OP_MULH) & rs2_val[XLEN-1]}}, rs2_val};
  assign mul_prod  = mul_a_ext * mul_b_ext;
  assign mul_res   = (op_q == OP_MUL) ? prod_q[XLEN-1:0] : prod_q[2*XLEN-1:XLEN];

  assign div_start = accept && is_div_op(decode_op_i) && !div_busy;

  exec_div_iter #(
    .XLEN (XLEN)
  ) u_div (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (div_start),
    .signed_i (decode_op_i inside {OP_DIV, OP_REM}),
    .a_i      (rs1_val),
    .b_i      (rs2_val),
    .busy_o   (div_busy),
    .done_o   (div_done),
    .quot_o   (div_quot),
    .rem_o    (div_rem)
  );

  assign wb_res = is_mul_op(op_q) ? mul_res
                : ((op_q inside {OP_REM, OP_REMU}) ? div_rem : div_quot);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    ctrl_d      = ctrl_q;
    rd_d        = rd_q;
    data_d      = data_q;
    prod_d      = prod_q;
    mem_valid_d = mem_valid_q && !mem_ready_i;
    mem_ctrl_d  = mem_ctrl_q;
    mem_res_d   = mem_res_q;
    mem_data_d  = mem_data_q;
    mem_rd_d    = mem_rd_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mul_op(decode_op_i) || is_div_op(decode_op_i)) begin
            op_d    = decode_op_i;
            ctrl_d  = decode_control_i;
            rd_d    = decode_rd_addr_i;
            data_d  = rs2_val;
            prod_d  = mul_prod;
            cnt_d   = CW'(1);
            state_d = is_div_op(decode_op_i) ? DIV : ((MUL_CYCLES == 1) ? WB : MUL);
          end else begin
            mem_valid_d = 1'b1;
            mem_ctrl_d  = decode_control_i;
            mem_res_d   = (decode_br_i inside {BR_JAL, BR_JALR}) ? link_addr : alu_res;
            mem_data_d  = rs2_val;
            mem_rd_d    = decode_rd_addr_i;
          end
        end
      end
      MUL: begin
        if (cnt_q == MUL_LAST) state_d = WB;
        else cnt_d = cnt_q + CW'(1);
      end
      DIV: begin
        if (div_done) state_d = WB;
      end
      WB: begin
        if (out_free) begin
          mem_valid_d = 1'b1;
          mem_ctrl_d  = ctrl_q;
          mem_res_d   = wb_res;
          mem_data_d  = data_q;
          mem_rd_d    = rd_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= OP_ADD;
      ctrl_q      <= '0;
      rd_q        <= '0;
      data_q      <= '0;
      prod_q      <= '0;
      mem_valid_q <= 1'b0;
      mem_ctrl_q  <= '0;
      mem_res_q   <= '0;
      mem_data_q  <= '0;
      mem_rd_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      ctrl_q      <= ctrl_d;
      rd_q        <= rd_d;
      data_q      <= data_d;
      prod_q      <= prod_d;
      mem_valid_q <= mem_valid_d;
      mem_ctrl_q  <= mem_ctrl_d;
      mem_res_q   <= mem_res_d;
      mem_data_q  <= mem_data_d;
      mem_rd_q    <= mem_rd_d;
    end
  end

  assign mem_valid_o   = mem_valid_q;
  assign mem_control_o = mem_ctrl_q;
  assign mem_result_o  = mem_res_q;
  assign mem_data_o    = mem_data_q;
  assign mem_rd_addr_o = mem_rd_q;

endmodule
